// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port between
// NREQ valid/ready requesters. Each grant lasts up to BURST accepted words
// so that a requester's data lands contiguously in the FIFO. Every change
// of ownership passes through one IDLE cycle, which keeps grant_id clean.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 32,
  parameter int BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*WIDTH-1:0]     req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic [WIDTH-1:0]          fifo_wdata,
  output logic                      fifo_we,
  input  logic                      fifo_full,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(BURST) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(BURST - 1);
  localparam logic [IDW-1:0] ID_MAX   = IDW'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] owner_nxt;
  logic [IDW-1:0] last;
  logic [IDW-1:0] last_nxt;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_nxt;

  logic [IDW-1:0] pick;
  logic           pick_found;
  logic           owner_valid;
  logic [WIDTH-1:0] owner_data;
  logic           accept;
  logic           burst_done;

  // Index base+step modulo NREQ; step is 1..NREQ and base < NREQ, so one
  // conditional subtraction is enough even for non-power-of-2 NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                               input int step);
    int s;
    s = int'(base) + step;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search: first valid requester after the previous owner.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!pick_found && req_valid[wrap_idx(last, k)]) begin
        pick       = wrap_idx(last, k);
        pick_found = 1'b1;
      end
    end
  end

  // Select the registered owner's valid and data.
  always_comb begin
    owner_valid = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        owner_valid = req_valid[i];
        owner_data  = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // A word moves only while granted, the owner offers it and the FIFO has room.
  always_comb begin
    accept     = (state == GRANT) && owner_valid && !fifo_full;
    burst_done = accept && (count == CNT_LAST);
  end

  // State register: FSM state, owner, round-robin pointer and burst count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      owner <= '0;
      last  <= ID_MAX;
      count <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      count <= count_nxt;
    end
  end

  // Next-state logic: grant in IDLE, release on full burst or owner drop.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_nxt = GRANT;
          owner_nxt = pick;
          count_nxt = '0;
        end
      end
      GRANT: begin
        if (!owner_valid || burst_done) begin
          // Release: the owner becomes the lowest priority next round.
          state_nxt = IDLE;
          last_nxt  = owner;
          count_nxt = '0;
        end else if (accept) begin
          count_nxt = count + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs: combinational from the registered owner while granted, else 0.
  always_comb begin
    busy       = 1'b0;
    grant_id   = '0;
    req_ready  = '0;
    fifo_we    = 1'b0;
    fifo_wdata = '0;
    if (state == GRANT) begin
      busy     = 1'b1;
      grant_id = owner;
      for (int i = 0; i < NREQ; i++) begin
        req_ready[i] = (owner == IDW'(i)) && !fifo_full;
      end
      fifo_we    = owner_valid && !fifo_full;
      fifo_wdata = owner_valid ? owner_data : '0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus random traffic,
// with a per-requester scoreboard on the FIFO write side and a cycle-level
// behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int BURST = 4;
  localparam int IDW   = $clog2(NREQ);

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ready;
  logic [WIDTH-1:0]        fifo_wdata;
  logic                    fifo_we;
  logic                    fifo_full;
  logic [IDW-1:0]          grant_id;
  logic                    busy;

  fifo_wr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Words each requester still has to send, and words expected at the FIFO.
  logic [WIDTH-1:0] send_q [NREQ][$];
  logic [WIDTH-1:0] exp_q  [NREQ][$];

  logic [NREQ-1:0] hs_last = '0;
  logic [NREQ-1:0] en = '1;
  bit              rand_mode = 1'b0;
  int              wr_count = 0;
  int              grant_log[$];
  bit              prev_busy = 1'b0;

  // Reference model of the arbitration rules.
  bit             m_busy = 1'b0;
  bit [IDW-1:0]   m_owner = '0;
  bit [IDW-1:0]   m_last = IDW'(NREQ - 1);
  int             m_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input int i, input int n);
    logic [WIDTH-1:0] w;
    for (int k = 0; k < n; k++) begin
      w = $urandom;
      send_q[i].push_back(w);
      exp_q[i].push_back(w);
    end
  endtask

  // One clock of requester behaviour: retire accepted words, hold unaccepted
  // ones stable, present the next word when allowed.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs_last[i] && send_q[i].size() > 0) void'(send_q[i].pop_front());
      if (req_valid[i] && !hs_last[i]) begin
        // hold valid and data until accepted
      end else if (send_q[i].size() > 0 && en[i]) begin
        req_valid[i] = 1'b1;
        req_data[i*WIDTH +: WIDTH] = send_q[i][0];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i*WIDTH +: WIDTH] = $urandom;
      end
    end
    if (rand_mode) begin
      fifo_full = ($urandom_range(0, 4) == 0);
      en = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        if (send_q[i].size() < 6 && $urandom_range(0, 2) == 0) load(i, 1);
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    fifo_full = 1'b0;
    en = '1;
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      send_q[i].delete();
      exp_q[i].delete();
    end
    grant_log.delete();
    wr_count = 0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_we", fifo_we, 0);
    chk("rst_async_ready", req_ready, 0);
    chk("rst_async_wdata", fifo_wdata, 0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  function automatic int pending();
    int n = busy ? 1 : 0;
    for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic drain(input string name, input int maxc);
    int c = 0;
    while (pending() != 0 && c < maxc) begin
      step();
      c++;
    end
    chk({name, "_timeout"}, (c < maxc), 1);
    for (int i = 0; i < NREQ; i++)
      chk($sformatf("%s_lost_words_req%0d", name, i), exp_q[i].size(), 0);
  endtask

  task automatic check_grants(input string name, input int exp_order[$]);
    chk({name, "_grant_count"}, grant_log.size(), exp_order.size());
    for (int i = 0; i < exp_order.size(); i++) begin
      if (i < grant_log.size())
        chk($sformatf("%s_grant%0d", name, i), grant_log[i], exp_order[i]);
    end
  endtask

  // Monitor: compare DUT outputs with the model, score FIFO writes, advance model.
  always @(negedge clk) begin : mon
    logic [NREQ-1:0]  e_ready;
    logic [WIDTH-1:0] e_wdata;
    bit               ov;
    bit               found;
    int               idx;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_we", fifo_we, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_wdata", fifo_wdata, 0);
      chk("rst_grant_id", grant_id, 0);
      m_busy = 1'b0;
      m_last = IDW'(NREQ - 1);
      m_owner = '0;
      m_cnt = 0;
      hs_last = '0;
      prev_busy = 1'b0;
    end else begin
      ov = m_busy && req_valid[m_owner];
      e_ready = (m_busy && !fifo_full) ? (NREQ'(1) << m_owner) : '0;
      e_wdata = ov ? req_data[m_owner*WIDTH +: WIDTH] : '0;
      chk("busy", busy, m_busy);
      if (m_busy) chk("grant_id", grant_id, m_owner);
      chk("req_ready", req_ready, e_ready);
      chk("fifo_we", fifo_we, (ov && !fifo_full));
      chk("fifo_wdata", fifo_wdata, e_wdata);
      chk("write_while_full", (fifo_we && fifo_full), 0);
      if (fifo_we) begin
        wr_count++;
        if (exp_q[grant_id].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_word: got %0h from req %0d expected no word", fifo_wdata, grant_id);
        end else begin
          chk("sb_data", fifo_wdata, exp_q[grant_id].pop_front());
        end
      end
      if (busy && !prev_busy) grant_log.push_back(int'(grant_id));
      prev_busy = busy;
      hs_last = req_valid & req_ready;
      // Advance the model to the state after the coming clock edge.
      if (!m_busy) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          idx = (int'(m_last) + k) % NREQ;
          if (!found && req_valid[idx]) begin
            found = 1'b1;
            m_owner = IDW'(idx);
          end
        end
        if (found) begin
          m_busy = 1'b1;
          m_cnt = 0;
        end
      end else if (!req_valid[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (!fifo_full) begin
        m_cnt++;
        if (m_cnt == BURST) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int c;
    int w0;
    req_valid = '0;
    req_data = '0;
    fifo_full = 1'b0;
    #2;
    do_reset();

    // Single requester 2 with three words.
    load(2, 3);
    drain("t1", 50);
    chk("t1_writes", wr_count, 3);
    check_grants("t1", '{2});

    // All requesters busy: rotation 0,1,2,3 with full bursts.
    do_reset();
    for (int i = 0; i < NREQ; i++) load(i, 8);
    drain("t2", 200);
    chk("t2_writes", wr_count, 32);
    check_grants("t2", '{0, 1, 2, 3, 0, 1, 2, 3});

    // FIFO full for five cycles after two words of a burst.
    do_reset();
    load(1, 4);
    c = 0;
    while (wr_count < 2 && c < 20) begin step(); c++; end
    chk("t3_wait_timeout", (c < 20), 1);
    w0 = wr_count;
    fifo_full = 1'b1;
    repeat (5) step();
    chk("t3_stall_writes", wr_count, w0);
    chk("t3_stall_busy", busy, 1);
    fifo_full = 1'b0;
    drain("t3", 50);
    chk("t3_writes", wr_count, 4);
    check_grants("t3", '{1});

    // Reset in the middle of a burst, then 3 and 0 request together.
    do_reset();
    load(1, 4);
    c = 0;
    while (wr_count < 2 && c < 20) begin step(); c++; end
    chk("t4_wait_timeout", (c < 20), 1);
    chk("t4_busy_before_reset", busy, 1);
    do_reset();
    load(3, 1);
    load(0, 1);
    drain("t4", 50);
    chk("t4_writes", wr_count, 2);
    check_grants("t4", '{0, 3});

    // Owner drops valid after one word while requester 1 waits.
    do_reset();
    load(0, 1);
    load(1, 2);
    drain("t5", 50);
    chk("t5_writes", wr_count, 3);
    check_grants("t5", '{0, 1});

    // Random traffic with random FIFO back-pressure.
    do_reset();
    rand_mode = 1'b1;
    repeat (10000) step();
    rand_mode = 1'b0;
    fifo_full = 1'b0;
    en = '1;
    drain("t6", 500);
    chk("t6_activity", (wr_count > 1000), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
